// File: rtl/adc_sequencer_if.sv
// Command/response channel between the sequencer and the ADC controller.
// Handshake rules:
//   command:  valid stays high and channel stays stable until a cycle where
//             ready is high. That cycle transfers the command.
//   response: valid is a one-cycle strobe. The ADC cannot be backpressured.
interface adc_sequencer_if;
    logic        command_valid;
    logic [4:0]  command_channel;
    logic        command_startofpacket;
    logic        command_endofpacket;
    logic        command_ready;
    logic        response_valid;
    logic [4:0]  response_channel;
    logic [11:0] response_data;

    modport master (
        output command_valid, command_channel, command_startofpacket, command_endofpacket,
        input  command_ready, response_valid, response_channel, response_data
    );

    modport slave (
        input  command_valid, command_channel, command_startofpacket, command_endofpacket,
        output command_ready, response_valid, response_channel, response_data
    );
endinterface

// File: rtl/adc_sequencer.sv
// Scans the enabled ADC channels in ascending order, one command/response pair
// per channel, and stores each matched result in a registered-read table.
module adc_sequencer #(
    parameter int NUM_CH  = 8,
    parameter int CH_BASE = 1,
    parameter int TIMEOUT = 1023,
    localparam int AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CW = $clog2(TIMEOUT + 1)
) (
    input  logic                  clock_clk,
    input  logic                  reset_sink_reset,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [NUM_CH-1:0]     ch_mask,
    input  logic                  err_clr,
    adc_sequencer_if.master       adc,
    input  logic [AW-1:0]         rd_addr,
    output logic [11:0]           rd_data,
    output logic                  sample_valid,
    output logic [4:0]            sample_channel,
    output logic [11:0]           sample_data,
    output logic                  scan_done,
    output logic                  busy,
    output logic                  error
);

    typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [11:0]         results [NUM_CH];
    logic                wr_en, err_set, done_d, advance;
    logic                nxt_found;
    logic [AW-1:0]       nxt_idx, low_idx;
    logic [4:0]          cur_ch;
    logic                resp_match;

    assign cur_ch     = 5'(CH_BASE) + 5'(idx_q);
    assign resp_match = adc.response_valid && (adc.response_channel == cur_ch);

    assign adc.command_valid         = (state_q == CMD);
    assign adc.command_channel       = cur_ch;
    assign adc.command_startofpacket = adc.command_valid;
    assign adc.command_endofpacket   = adc.command_valid;
    assign busy                      = (state_q != IDLE);

    // Descending search so the last hit is the lowest qualifying bit.
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(idx_q))) begin
                nxt_found = 1'b1;
                nxt_idx   = AW'(i);
            end
        end
    end

    always_comb begin
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) low_idx = AW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        err_set = 1'b0;
        done_d  = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && (|ch_mask)) begin
                    mask_d  = ch_mask;
                    idx_d   = low_idx;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (adc.command_ready) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (resp_match) begin
                    wr_en   = 1'b1;
                    advance = 1'b1;
                end else begin
                    if (adc.response_valid) err_set = 1'b1;
                    // The response is abandoned after TIMEOUT unmatched WAIT cycles.
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        err_set = 1'b1;
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (nxt_found) begin
                idx_d   = nxt_idx;
                state_d = CMD;
            end else begin
                done_d = 1'b1;
                if (continuous && (|ch_mask)) begin
                    mask_d  = ch_mask;
                    idx_d   = low_idx;
                    state_d = CMD;
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            mask_q         <= '0;
            cnt_q          <= '0;
            sample_valid   <= 1'b0;
            sample_channel <= '0;
            sample_data    <= '0;
            scan_done      <= 1'b0;
            error          <= 1'b0;
            rd_data        <= '0;
            for (int i = 0; i < NUM_CH; i++) results[i] <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            sample_valid <= wr_en;
            scan_done    <= done_d;
            if (wr_en) begin
                sample_channel <= cur_ch;
                sample_data    <= adc.response_data;
                results[idx_q] <= adc.response_data;
            end
            // A set wins over a clear arriving in the same cycle.
            if (err_set)      error <= 1'b1;
            else if (err_clr) error <= 1'b0;
            rd_data <= (int'(rd_addr) < NUM_CH) ? results[rd_addr] : '0;
        end
    end

endmodule
